// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the fetch program counter
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_t;

  typedef enum logic [2:0] {
    SEQ,
    BRANCH,
    JALR,
    TRAP,
    HOLD
  } pc_src_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_chk.sv
// rtl/pc_target_chk.sv - combinational alignment check for a redirect target
module pc_target_chk #(
  parameter int XLEN    = 32,
  parameter bit ALIGN_C = 1'b0
) (
  input  logic [XLEN-1:0] target,
  output logic            misaligned
);

  // With compressed instructions only byte-odd targets are illegal.
  assign misaligned = target[0] | (!ALIGN_C && target[1]);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter with redirect priority, halt/resume and retire counter
module pc_gen
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter bit              ALIGN_C   = 1'b0,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_offset,
  input  logic             jalr_valid,
  input  logic [XLEN-1:0]  jalr_base,
  input  logic [XLEN-1:0]  jalr_imm,
  input  logic             trap_valid,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             misalign,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  pc_state_t       state_q, state_d;
  pc_src_t         src;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] redirect_target;
  logic            target_bad;
  logic            fire;
  logic            misalign_d;

  assign pc_valid = (state_q == RUN);
  assign halted   = (state_q == HALT);
  assign fire     = pc_valid && fetch_ready && !stall;

  // JALR outranks a branch, so only one redirect target needs checking.
  assign jalr_sum        = jalr_base + jalr_imm;
  assign redirect_target = jalr_valid ? {jalr_sum[XLEN-1:1], 1'b0}
                                      : pc + branch_offset;

  pc_target_chk #(
    .XLEN    (XLEN),
    .ALIGN_C (ALIGN_C)
  ) u_target_chk (
    .target     (redirect_target),
    .misaligned (target_bad)
  );

  always_comb begin
    state_d    = state_q;
    src        = HOLD;
    misalign_d = 1'b0;
    pc_d       = pc;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_valid)        src = TRAP;
        else if (halt_req)     state_d = HALT;
        else if (jalr_valid)   src = JALR;
        else if (branch_taken) src = BRANCH;
        else if (fire)         src = SEQ;
      end
      HALT: begin
        if (trap_valid) begin
          src     = TRAP;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    case (src)
      SEQ:  pc_d = pc + XLEN'(INSTR_BYTES);
      TRAP: pc_d = TRAP_VEC;
      BRANCH, JALR: begin
        misalign_d = target_bad;
        pc_d       = target_bad ? TRAP_VEC : redirect_target;
      end
      default: pc_d = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      pc       <= RESET_VEC;
      misalign <= 1'b0;
      retired  <= '0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      misalign <= misalign_d;
      if (fire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the single-cycle RISC-V core. It replaces the fixed 32-bit counter with one that has a configurable width, reset and trap vectors, and a fetch valid/ready handshake. It selects among sequential, branch, JALR and trap targets with fixed priority, checks target alignment, supports halt and resume, and counts retired fetches. It sits between the execute/branch unit and instruction memory.

## Interface
- `XLEN`, default 32: PC and offset width.
- `RESET_VEC`, default 0: PC value loaded on reset.
- `TRAP_VEC`, default 32'h0000_0100: PC value loaded on trap or misaligned target.
- `ALIGN_C`, default 0: 1 allows 2-byte-aligned targets (compressed ISA); 0 requires 4-byte alignment.
- `CNT_W`, default 32: width of the retire counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `fetch_ready`  in  1  instruction memory accepts `pc` this cycle.
- `stall`  in  1  freeze sequential advance.
- `branch_taken`  in  1  branch/JAL redirect request.
- `branch_offset`  in  XLEN  signed offset, added to the current `pc`.
- `jalr_valid`  in  1  JALR redirect request.
- `jalr_base`, `jalr_imm`  in  XLEN each  JALR operands (imm signed).
- `trap_valid`  in  1  trap redirect request.
- `halt_req`  in  1  program finished; stop fetching.
- `resume`  in  1  leave HALT.
- `pc`  out  XLEN  current fetch address.
- `pc_valid`  out  1  `pc` is a valid fetch request.
- `misalign`  out  1  one-cycle pulse: the requested target was misaligned.
- `halted`  out  1  state == HALT.
- `retired`  out  CNT_W  count of accepted fetches.

## Operation
- States: BOOT, RUN, HALT.
- Reset values: `pc`=RESET_VEC, state BOOT, `pc_valid`=0, `misalign`=0, `halted`=0, `retired`=0.
- BOOT: lasts exactly one cycle after reset deassertion, then moves to RUN. All inputs are ignored.
- RUN: `pc_valid`=1.
  - A fetch fires when `pc_valid && fetch_ready && !stall`.
- Next-PC priority in RUN, highest first:
  1. `trap_valid` → TRAP_VEC.
  2. `halt_req` → `pc` holds; next state HALT.
  3. `jalr_valid` → (`jalr_base` + `jalr_imm`) with bit 0 cleared.
  4. `branch_taken` → `pc` + `branch_offset`.
  5. fire → `pc` + 4.
  6. Otherwise `pc` holds.
- Redirects (priorities 1, 3, 4) are taken regardless of `stall` or `fetch_ready`. `stall` blocks only the sequential advance.
- Alignment check, applied to JALR and branch targets:
  - A target is misaligned if bit 0 is set, or if bit 1 is set while ALIGN_C=0.
  - A misaligned target is not loaded. Instead `pc` <= TRAP_VEC and `misalign` pulses high for one cycle.
- HALT: `pc_valid`=0 and `pc` holds.
  - `resume` → RUN with `pc` unchanged.
  - `trap_valid` → RUN with `pc`=TRAP_VEC; this takes priority over `resume`.
  - All other inputs are ignored.
- Arithmetic is modulo 2^XLEN. 0xFFFF_FFFC + 4 yields 0, with no flag.
- `retired` increments by 1 on each fire and wraps at 2^CNT_W.
  - A redirect and a fire may occur in the same cycle. The fetch still counts, and the redirect target wins for `pc`.

## Timing
- A request at a rising edge in cycle n is visible on `pc` in cycle n+1. There is one cycle of redirect latency and no bypass.
- First valid fetch: the second rising edge after reset deassertion (the BOOT cycle comes first).
- `misalign` is registered and high only in cycle n+1.
- `halted` is asserted the cycle after `halt_req` is sampled.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous), regardless of state.
- `halt_req` and `branch_taken` in the same cycle: the halt wins, and the branch is dropped.

## Structure
- Shared package `riscv_pkg` holds:
  - the `pc_state_t` enum (BOOT, RUN, HALT);
  - the next-PC source enum (SEQ, BRANCH, JALR, TRAP, HOLD);
  - the constant INSTR_BYTES = 4.
- Sub-module `pc_target_chk` is combinational. It takes a target and ALIGN_C and outputs a misaligned flag. It is instantiated once for the selected redirect target.
- Everything else (state register, next-PC mux, counter) lives in `pc_gen`.

## Test plan
- Reset release, `fetch_ready`=1: BOOT cycle with `pc_valid`=0, then `pc` = 0, 4, 8, 12; `retired`=3 after three fires.
- `stall`=1 for 2 cycles at `pc`=8, with `branch_taken` and offset -8 asserted in the second cycle → `pc`=0 next cycle.
- `jalr_base`=0x101, `jalr_imm`=2, ALIGN_C=0 → target 0x102 is misaligned → `pc`=0x100 and a one-cycle `misalign` pulse. With ALIGN_C=1 the same inputs give `pc`=0x102.
- `trap_valid`, `jalr_valid` and `halt_req` together → `pc`=TRAP_VEC, state RUN. Next cycle `halt_req` alone → `halted`=1 and `pc` frozen. Then `resume` → RUN with the same `pc`.
- `pc`=0xFFFF_FFFC, fire → `pc`=0. With CNT_W=4 and `retired`=15, one fire → 0.
- Assert `reset` asynchronously in HALT with `pc`=0x40 → `pc`=RESET_VEC and `halted`=0 before the next clock edge.
